// File: rtl/bp_cce_gad_stream.sv
// ----------------------------------------------------------------------------
// bp_cce_gad_stream
//
// Multi-beat generate-auxiliary-directory-info unit for the CCE. A request
// (requesting LCE, write flag, requester LRU coherence state) is accepted,
// then the directory way-group is streamed in lanes_p LCE entries per beat.
// Flags, the requester's hit way and the owner are accumulated across beats
// and presented once with a valid/yumi handshake.
//
// Handshakes (all valid/ready style, transfer on the rising clock edge):
//   gad_v_i & gad_ready_o      : request accepted
//   sharers_v_i & sharers_ready_o : one sharers beat accepted
//   v_o & yumi_i               : result consumed
//   Each valid is a request only; a transfer happens only when its partner
//   signal is high in the same cycle. yumi_i while v_o is low and
//   sharers_v_i outside the accumulate phase have no effect.
//
// Ports:
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   gad_v_i / gad_ready_o     request handshake
//   req_lce_i, req_wr_i, lru_coh_state_i   request fields
//   sharers_v_i / sharers_ready_o          sharers beat handshake
//   sharers_hits_i, sharers_ways_i, sharers_coh_states_i  per-lane beat data
//   v_o / yumi_i              result handshake
//   req_addr_way_o            requester hit way (0 on miss)
//   owner_lce_o, owner_way_o, owner_coh_state_o, owner_v_o, owner_conflict_o
//   upgrade_flag_o, replacement_flag_o, cached_*_flag_o
//   state_o                   FSM state for observation (IDLE=0 ACCUM=1 DONE=2)
// ----------------------------------------------------------------------------
module bp_cce_gad_stream #(
    parameter int num_lce_p      = 8,
    parameter int lanes_p        = 2,
    parameter int lce_assoc_p    = 8,
    parameter int lce_id_width_p = 4,
    localparam int way_w_lp      = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,

    input  logic                          gad_v_i,
    output logic                          gad_ready_o,
    input  logic [lce_id_width_p-1:0]     req_lce_i,
    input  logic                          req_wr_i,
    input  logic [2:0]                    lru_coh_state_i,

    input  logic                          sharers_v_i,
    output logic                          sharers_ready_o,
    input  logic [lanes_p-1:0]            sharers_hits_i,
    input  logic [lanes_p*way_w_lp-1:0]   sharers_ways_i,
    input  logic [lanes_p*3-1:0]          sharers_coh_states_i,

    output logic                          v_o,
    input  logic                          yumi_i,

    output logic [way_w_lp-1:0]           req_addr_way_o,
    output logic [lce_id_width_p-1:0]     owner_lce_o,
    output logic [way_w_lp-1:0]           owner_way_o,
    output logic [2:0]                    owner_coh_state_o,
    output logic                          owner_v_o,
    output logic                          owner_conflict_o,
    output logic                          upgrade_flag_o,
    output logic                          replacement_flag_o,
    output logic                          cached_shared_flag_o,
    output logic                          cached_exclusive_flag_o,
    output logic                          cached_modified_flag_o,
    output logic                          cached_owned_flag_o,
    output logic                          cached_forward_flag_o,

    output logic [1:0]                    state_o
);

    localparam int beats_lp = (num_lce_p + lanes_p - 1) / lanes_p;
    localparam int cnt_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;

    localparam logic [2:0] coh_i = 3'b000;
    localparam logic [2:0] coh_s = 3'b001;
    localparam logic [2:0] coh_e = 3'b010;
    localparam logic [2:0] coh_f = 3'b011;
    localparam logic [2:0] coh_m = 3'b110;
    localparam logic [2:0] coh_o = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                    state_r;
    logic [cnt_w_lp-1:0]       cnt_r;
    logic [lce_id_width_p-1:0] req_lce_r;
    logic                      req_wr_r;
    logic [2:0]                lru_r;
    logic                      req_ro_r;

    logic start;
    logic beat;
    logic last_beat;
    logic consume;

    // Next values of the accumulators after merging the current beat
    logic [way_w_lp-1:0]       n_req_way;
    logic                      n_req_ro;
    logic [lce_id_width_p-1:0] n_owner_lce;
    logic [way_w_lp-1:0]       n_owner_way;
    logic [2:0]                n_owner_st;
    logic                      n_owner_v;
    logic                      n_conflict;
    logic                      n_shared;
    logic                      n_exclusive;
    logic                      n_modified;
    logic                      n_owned;
    logic                      n_forward;
    logic                      n_upgrade;
    logic                      n_replace;

    int                        lce_idx;
    logic [2:0]                lane_st;
    logic [way_w_lp-1:0]       lane_way;
    logic                      is_req;

    // In DONE a new request is only taken in the cycle the result is consumed,
    // which gives back-to-back operation with no bubble.
    assign gad_ready_o     = (state_r == IDLE) | ((state_r == DONE) & yumi_i);
    assign sharers_ready_o = (state_r == ACCUM);
    assign v_o             = (state_r == DONE);
    assign state_o         = state_r;

    assign start     = gad_v_i & gad_ready_o;
    assign beat      = sharers_v_i & sharers_ready_o;
    assign last_beat = beat & (cnt_r == cnt_w_lp'(beats_lp - 1));
    assign consume   = (state_r == DONE) & yumi_i;

    // Merge one beat into the accumulated result. Lanes are walked in
    // ascending order so the lowest LCE index claims ownership first.
    always_comb begin
        n_req_way   = req_addr_way_o;
        n_req_ro    = req_ro_r;
        n_owner_lce = owner_lce_o;
        n_owner_way = owner_way_o;
        n_owner_st  = owner_coh_state_o;
        n_owner_v   = owner_v_o;
        n_conflict  = owner_conflict_o;
        n_shared    = cached_shared_flag_o;
        n_exclusive = cached_exclusive_flag_o;
        n_modified  = cached_modified_flag_o;
        n_owned     = cached_owned_flag_o;
        n_forward   = cached_forward_flag_o;
        lce_idx     = 0;
        lane_st     = coh_i;
        lane_way    = '0;
        is_req      = 1'b0;

        for (int l = 0; l < lanes_p; l++) begin
            lce_idx  = int'(cnt_r) * lanes_p + l;
            lane_st  = sharers_coh_states_i[3*l +: 3];
            lane_way = sharers_ways_i[way_w_lp*l +: way_w_lp];
            // An out-of-range req_lce never equals an in-range LCE index,
            // so such a request simply has no requester entry.
            is_req   = (lce_idx == int'(req_lce_r));

            // Lanes past num_lce_p only occur in a final partial beat.
            if ((lce_idx < num_lce_p) && sharers_hits_i[l]) begin
                if (is_req) begin
                    n_req_way = lane_way;
                    n_req_ro  = (lane_st == coh_s) | (lane_st == coh_f) | (lane_st == coh_o);
                end else begin
                    case (lane_st)
                        coh_s:   n_shared    = 1'b1;
                        coh_e:   n_exclusive = 1'b1;
                        coh_m:   n_modified  = 1'b1;
                        coh_o:   n_owned     = 1'b1;
                        coh_f:   n_forward   = 1'b1;
                        default: ;
                    endcase
                end

                // Owner states count for every LCE, requester included.
                if ((lane_st == coh_e) | (lane_st == coh_m) |
                    (lane_st == coh_o) | (lane_st == coh_f)) begin
                    if (n_owner_v) begin
                        n_conflict = 1'b1;
                    end else begin
                        n_owner_v   = 1'b1;
                        n_owner_lce = lce_id_width_p'(lce_idx);
                        n_owner_way = lane_way;
                        n_owner_st  = lane_st;
                    end
                end
            end
        end

        n_upgrade = req_wr_r & n_req_ro;
        n_replace = ~n_upgrade & ((lru_r == coh_e) | (lru_r == coh_m) | (lru_r == coh_o));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r                 <= IDLE;
            cnt_r                   <= '0;
            req_lce_r               <= '0;
            req_wr_r                <= 1'b0;
            lru_r                   <= coh_i;
            req_ro_r                <= 1'b0;
            req_addr_way_o          <= '0;
            owner_lce_o             <= '0;
            owner_way_o             <= '0;
            owner_coh_state_o       <= coh_i;
            owner_v_o               <= 1'b0;
            owner_conflict_o        <= 1'b0;
            upgrade_flag_o          <= 1'b0;
            replacement_flag_o      <= 1'b0;
            cached_shared_flag_o    <= 1'b0;
            cached_exclusive_flag_o <= 1'b0;
            cached_modified_flag_o  <= 1'b0;
            cached_owned_flag_o     <= 1'b0;
            cached_forward_flag_o   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        // Covers both the idle accept and the accept that
                        // coincides with yumi_i in DONE.
                        state_r                 <= ACCUM;
                        cnt_r                   <= '0;
                        req_lce_r               <= req_lce_i;
                        req_wr_r                <= req_wr_i;
                        lru_r                   <= lru_coh_state_i;
                        req_ro_r                <= 1'b0;
                        req_addr_way_o          <= '0;
                        owner_lce_o             <= '0;
                        owner_way_o             <= '0;
                        owner_coh_state_o       <= coh_i;
                        owner_v_o               <= 1'b0;
                        owner_conflict_o        <= 1'b0;
                        upgrade_flag_o          <= 1'b0;
                        replacement_flag_o      <= 1'b0;
                        cached_shared_flag_o    <= 1'b0;
                        cached_exclusive_flag_o <= 1'b0;
                        cached_modified_flag_o  <= 1'b0;
                        cached_owned_flag_o     <= 1'b0;
                        cached_forward_flag_o   <= 1'b0;
                    end else if (consume) begin
                        state_r <= IDLE;
                    end
                end

                ACCUM: begin
                    if (beat) begin
                        req_addr_way_o          <= n_req_way;
                        req_ro_r                <= n_req_ro;
                        owner_lce_o             <= n_owner_lce;
                        owner_way_o             <= n_owner_way;
                        owner_coh_state_o       <= n_owner_st;
                        owner_v_o               <= n_owner_v;
                        owner_conflict_o        <= n_conflict;
                        cached_shared_flag_o    <= n_shared;
                        cached_exclusive_flag_o <= n_exclusive;
                        cached_modified_flag_o  <= n_modified;
                        cached_owned_flag_o     <= n_owned;
                        cached_forward_flag_o   <= n_forward;
                        if (last_beat) begin
                            cnt_r              <= '0;
                            upgrade_flag_o     <= n_upgrade;
                            replacement_flag_o <= n_replace;
                            state_r            <= DONE;
                        end else begin
                            cnt_r <= cnt_r + cnt_w_lp'(1);
                        end
                    end
                end

                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
